// File: rtl/mcp3002_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mcp3002_responder                                               |
// | Purpose  : Emulates the SPI target side of an MCP3002 10-bit ADC.          |
// |            Optional LSB-first tail: define MCP3002_LSB_TAIL_EN.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mcp3002_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        _i_clk,
    input  logic        _i_rst,
    input  logic        _i_sclk_unsync,
    input  logic        _i_mosi_unsync,
    input  logic        _i_cs_unsync,
    input  logic [9:0]  _i_ch0_value,
    input  logic [9:0]  _i_ch1_value,
    output logic [13:0] __output
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        CONFIG     = 3'd2,
        NULLBIT    = 3'd3,
        DATA       = 3'd4,
        TAIL       = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam logic [3:0] c_MSB_IDX = 4'd9;

    // Reset asserts immediately but is released only on a clock edge.
    logic [1:0] r_rst_pipe;
    logic       w_rst;

    always_ff @(posedge _i_clk or posedge _i_rst) begin
        if (_i_rst) begin
            r_rst_pipe <= 2'b11;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b0};
        end
    end

    assign w_rst = r_rst_pipe[1];

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_cs_s;
    logic                   w_cs_fall;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

    always_ff @(posedge _i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], _i_sclk_unsync};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], _i_mosi_unsync};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], _i_cs_unsync};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    // An sclk edge coinciding with the cs fall is not part of the frame.
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d & ~w_cs_fall;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d & ~w_cs_fall;

    state_t     r_state;
    state_t     w_nxt_state;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_nxt_cnt;
    logic       r_sgl;
    logic       w_nxt_sgl;
    logic       r_odd;
    logic       w_nxt_odd;
    logic [9:0] r_code;
    logic [9:0] w_nxt_code;
    logic [9:0] w_conv;
    logic       r_miso;
    logic       w_nxt_miso;
    logic       r_miso_oe;
    logic       w_nxt_oe;
    logic       r_frame_done;
    logic       w_nxt_done;
    logic [9:0] r_last_code;
    logic [9:0] w_nxt_last_code;
    logic       r_last_channel;
    logic       w_nxt_last_ch;
`ifdef MCP3002_LSB_TAIL_EN
    logic       r_msbf;
    logic       w_nxt_msbf;
`endif

    // Differential results clamp at zero instead of wrapping.
    always_comb begin
        w_conv = '0;
        if (r_sgl) begin
            w_conv = r_odd ? _i_ch1_value : _i_ch0_value;
        end else if (!r_odd) begin
            if (_i_ch0_value >= _i_ch1_value) w_conv = _i_ch0_value - _i_ch1_value;
        end else begin
            if (_i_ch1_value >= _i_ch0_value) w_conv = _i_ch1_value - _i_ch0_value;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cnt       = r_bit_cnt;
        w_nxt_sgl       = r_sgl;
        w_nxt_odd       = r_odd;
        w_nxt_code      = r_code;
        w_nxt_miso      = r_miso;
        w_nxt_done      = 1'b0;
        w_nxt_last_code = r_last_code;
        w_nxt_last_ch   = r_last_channel;
`ifdef MCP3002_LSB_TAIL_EN
        w_nxt_msbf      = r_msbf;
`endif
        if (w_cs_s) begin
            w_nxt_state = IDLE;
            w_nxt_miso  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_nxt_state = WAIT_START;
                    w_nxt_miso  = 1'b0;
                end
                WAIT_START: begin
                    w_nxt_miso = 1'b0;
                    if (w_sclk_rise && w_mosi_s) begin
                        w_nxt_state = CONFIG;
                        w_nxt_cnt   = 4'd0;
                    end
                end
                CONFIG: begin
                    w_nxt_miso = 1'b0;
                    if (w_sclk_rise) begin
                        w_nxt_cnt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd0) begin
                            w_nxt_sgl = w_mosi_s;
                        end else if (r_bit_cnt == 4'd1) begin
                            w_nxt_odd = w_mosi_s;
                        end else begin
`ifdef MCP3002_LSB_TAIL_EN
                            w_nxt_msbf = w_mosi_s;
`endif
                            w_nxt_code  = w_conv;
                            w_nxt_state = NULLBIT;
                        end
                    end
                end
                NULLBIT: begin
                    if (w_sclk_fall) begin
                        w_nxt_miso  = 1'b0;
                        w_nxt_cnt   = c_MSB_IDX;
                        w_nxt_state = DATA;
                    end
                end
                DATA: begin
                    if (w_sclk_fall) begin
                        w_nxt_miso = r_code[r_bit_cnt];
                        if (r_bit_cnt == 4'd0) begin
                            w_nxt_done      = 1'b1;
                            w_nxt_last_code = r_code;
                            w_nxt_last_ch   = r_odd;
`ifdef MCP3002_LSB_TAIL_EN
                            if (!r_msbf) begin
                                w_nxt_state = TAIL;
                                w_nxt_cnt   = 4'd1;
                            end else begin
                                w_nxt_state = DONE;
                            end
`else
                            w_nxt_state = DONE;
`endif
                        end else begin
                            w_nxt_cnt = r_bit_cnt - 4'd1;
                        end
                    end
                end
`ifdef MCP3002_LSB_TAIL_EN
                TAIL: begin
                    if (w_sclk_fall) begin
                        w_nxt_miso = r_code[r_bit_cnt];
                        if (r_bit_cnt == c_MSB_IDX) begin
                            w_nxt_state = DONE;
                        end else begin
                            w_nxt_cnt = r_bit_cnt + 4'd1;
                        end
                    end
                end
`endif
                DONE: begin
                    if (w_sclk_fall) w_nxt_miso = 1'b0;
                end
                default: begin
                    w_nxt_state = IDLE;
                    w_nxt_miso  = 1'b0;
                end
            endcase
        end
        w_nxt_oe = (w_nxt_state != IDLE) && (w_nxt_state != WAIT_START);
    end

    always_ff @(posedge _i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state        <= IDLE;
            r_bit_cnt      <= '0;
            r_sgl          <= 1'b0;
            r_odd          <= 1'b0;
            r_code         <= '0;
            r_miso         <= 1'b0;
            r_miso_oe      <= 1'b0;
            r_frame_done   <= 1'b0;
            r_last_code    <= '0;
            r_last_channel <= 1'b0;
`ifdef MCP3002_LSB_TAIL_EN
            r_msbf         <= 1'b0;
`endif
        end else begin
            r_state        <= w_nxt_state;
            r_bit_cnt      <= w_nxt_cnt;
            r_sgl          <= w_nxt_sgl;
            r_odd          <= w_nxt_odd;
            r_code         <= w_nxt_code;
            r_miso         <= w_nxt_miso;
            r_miso_oe      <= w_nxt_oe;
            r_frame_done   <= w_nxt_done;
            r_last_code    <= w_nxt_last_code;
            r_last_channel <= w_nxt_last_ch;
`ifdef MCP3002_LSB_TAIL_EN
            r_msbf         <= w_nxt_msbf;
`endif
        end
    end

    assign __output = {r_miso & r_miso_oe, r_miso_oe, r_frame_done, r_last_channel, r_last_code};

endmodule
`default_nettype wire

// File: tb/tb_mcp3002_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mcp3002_responder                                            |
// | Purpose  : Scoreboard bench for mcp3002_responder (miso and frame results). |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mcp3002_responder;

    localparam int SYNC = 2;
    localparam int HALF = 6;
`ifdef MCP3002_LSB_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs   = 1'b1;
    logic [9:0]  ch0  = '0;
    logic [9:0]  ch1  = '0;
    logic [13:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    bit          exp_miso_q[$];
    logic [10:0] exp_frame_q[$];

    mcp3002_responder #(.SYNC_STAGES(SYNC)) dut (
        ._i_clk        (clk),
        ._i_rst        (rst),
        ._i_sclk_unsync(sclk),
        ._i_mosi_unsync(mosi),
        ._i_cs_unsync  (cs),
        ._i_ch0_value  (ch0),
        ._i_ch1_value  (ch1),
        .__output      (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Initiator samples miso on each sclk rise.
    always @(posedge sclk) begin
        if (!cs) begin
            if (exp_miso_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL miso_rise: unexpected sclk rise, miso=%0b", dout[13]);
            end else begin
                check("miso_rise", {31'd0, dout[13]}, {31'd0, exp_miso_q.pop_front()});
            end
        end
    end

    // Every frame_done cycle must match one queued frame result.
    always @(negedge clk) begin
        if (dout[11]) begin
            if (exp_frame_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL frame_done: unexpected pulse, last_code=0x%0h", dout[9:0]);
            end else begin
                logic [10:0] e;
                e = exp_frame_q.pop_front();
                check("last_code", {22'd0, dout[9:0]}, {22'd0, e[9:0]});
                check("last_channel", {31'd0, dout[10]}, {31'd0, e[10]});
            end
        end
    end

    task automatic cs_low();
        cs = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic cs_high();
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(4 * HALF);
    endtask

    // Drives nrises sclk cycles; code is the hand-computed conversion result.
    task automatic frame(input int lead, input bit sgl, input bit odd, input bit msbf,
                         input int nrises, input logic [9:0] code);
        int k;
        bit m;
        bit e;
        k = lead + 4;
        if (nrises >= k + 10) exp_frame_q.push_back({odd, code});
        for (int r = 0; r < nrises; r++) begin
            if (r < lead)           m = 1'b0;
            else if (r == lead)     m = 1'b1;
            else if (r == lead + 1) m = sgl;
            else if (r == lead + 2) m = odd;
            else if (r == lead + 3) m = msbf;
            else                    m = 1'b0;
            if (r >= k + 1 && r <= k + 10)
                e = code[9 - (r - k - 1)];
            else if (TAIL_EN && !msbf && r >= k + 11 && r <= k + 19)
                e = code[r - k - 10];
            else
                e = 1'b0;
            mosi = m;
            wait_clk(HALF);
            exp_miso_q.push_back(e);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        wait_clk(3);
        check("reset_out", {18'd0, dout}, 32'd0);
        rst = 1'b0;
        wait_clk(5);
        check("idle_out", {18'd0, dout}, 32'd0);

        // Single-ended CH0, MSB first.
        ch0 = 10'h2A5; ch1 = 10'h0F0;
        cs_low();
        frame(0, 1'b1, 1'b0, 1'b1, 16, 10'h2A5);
        cs_high();
        check("t1_last_code", {22'd0, dout[9:0]}, 32'h2A5);
        check("t1_last_channel", {31'd0, dout[10]}, 32'd0);

        // Differential, negative result clamps to zero.
        ch0 = 10'h100; ch1 = 10'h180;
        cs_low();
        frame(0, 1'b0, 1'b0, 1'b1, 16, 10'h000);
        cs_high();

        // Differential, ch1 - ch0.
        cs_low();
        frame(0, 1'b0, 1'b1, 1'b1, 16, 10'h080);
        cs_high();

        // Abort after five sclk cycles.
        ch0 = 10'h3C3;
        cs_low();
        frame(0, 1'b1, 1'b0, 1'b1, 5, 10'h3C3);
        check("oe_before_abort", {31'd0, dout[12]}, 32'd1);
        cs = 1'b1;
        wait_clk(SYNC + 2);
        check("oe_after_abort", {31'd0, dout[12]}, 32'd0);
        check("miso_after_abort", {31'd0, dout[13]}, 32'd0);
        check("abort_last_code", {22'd0, dout[9:0]}, 32'h080);
        check("abort_last_channel", {31'd0, dout[10]}, 32'd1);
        wait_clk(4 * HALF);
        cs_low();
        frame(0, 1'b1, 1'b0, 1'b1, 16, 10'h3C3);
        cs_high();

        // Leading zeros before the start bit, all-ones code.
        ch1 = 10'h3FF;
        cs_low();
        frame(3, 1'b1, 1'b1, 1'b1, 18, 10'h3FF);
        cs_high();

        // MSBF=0 over 24 sclk cycles.
        ch1 = 10'h2A5;
        cs_low();
        frame(0, 1'b1, 1'b1, 1'b0, 24, 10'h2A5);
        cs_high();

        // Differential, positive ch0 - ch1.
        ch0 = 10'h200; ch1 = 10'h05A;
        cs_low();
        frame(0, 1'b0, 1'b0, 1'b1, 16, 10'h1A6);
        cs_high();

        // Reset mid-DATA, then a new frame with cs still low.
        ch0 = 10'h155; ch1 = 10'h1FF;
        cs_low();
        frame(0, 1'b1, 1'b0, 1'b1, 8, 10'h155);
        rst = 1'b1;
        #1;
        check("out_in_reset", {18'd0, dout}, 32'd0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);
        check("out_after_reset", {18'd0, dout}, 32'd0);
        frame(0, 1'b0, 1'b1, 1'b1, 16, 10'h0AA);
        cs_high();

        wait_clk(20);
        check("miso_q_drained", exp_miso_q.size(), 32'd0);
        check("frame_q_drained", exp_frame_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcp3002_responder.md
MCP3002_RESPONDER -- requirements
Module: mcp3002_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of each input synchronizer (legal range 2..4).
REQ-002 SHALL have port _i_clk, input, 1 bit: system clock; all state on its rising edge.
REQ-003 SHALL have port _i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port _i_sclk_unsync, input, 1 bit: SPI clock from the initiator (mode 0,0), asynchronous to _i_clk.
REQ-005 SHALL have port _i_mosi_unsync, input, 1 bit: SPI data from the initiator (DIN), asynchronous.
REQ-006 SHALL have port _i_cs_unsync, input, 1 bit: active-low chip select, asynchronous.
REQ-007 SHALL have port _i_ch0_value, input, 10 bits: emulated CH0 code.
REQ-008 SHALL have port _i_ch1_value, input, 10 bits: emulated CH1 code.
REQ-009 SHALL have port __output, output, 14 bits, packed as [13] miso, [12] miso_oe, [11] frame_done, [10] last_channel, [9:0] last_code.

Function
REQ-010 SHALL pass sclk, mosi and cs through SYNC_STAGES-deep synchronizers, then detect rise and fall edges of sclk using one further registered stage.
REQ-011 SHALL use the FSM states IDLE, WAIT_START, CONFIG, NULLBIT, DATA, TAIL and DONE.
REQ-012 SHALL go from IDLE to WAIT_START when synchronized cs is low.
REQ-013 SHALL ignore sclk edges in the cycle in which cs falls.
REQ-014 SHALL, in WAIT_START, sample mosi on each sclk rise, stay in WAIT_START while it is 0 (leading zeros allowed), and move to CONFIG when it is 1.
REQ-015 SHALL, in CONFIG, sample SGL/DIFF, ODD/SIGN and MSBF on 3 consecutive sclk rises.
REQ-016 SHALL, on the MSBF rise, latch the conversion code and move to NULLBIT.
REQ-017 SHALL compute the code as follows: SGL=1 gives CHn, where n is ODD; SGL=0, ODD=0 gives ch0-ch1 if ch0>=ch1, else 0; SGL=0, ODD=1 gives ch1-ch0 if ch1>=ch0, else 0; all arithmetic is 10-bit unsigned with no wrap.
REQ-018 SHALL assert miso_oe in CONFIG and later states while cs is low.
REQ-019 SHALL drive miso=0 from WAIT_START through CONFIG.
REQ-020 SHALL update miso in the cycle after each detected sclk fall.
REQ-021 SHALL, in NULLBIT, drive miso=0 on the first fall and then enter DATA.
REQ-022 SHALL, in DATA, drive B9..B0 on 10 successive falls using a 4-bit counter that terminates at 0.
REQ-023 SHALL, on the fall that drives B0, pulse frame_done high for exactly one _i_clk cycle and update last_code/last_channel (last_channel = ODD).
REQ-024 SHALL, after B0, go to TAIL or DONE according to REQ-038..REQ-040.
REQ-025 SHALL, in DONE, drive miso=0 on every further fall until cs rises.
REQ-026 SHALL, on cs rise in any state, return to IDLE and drop miso_oe and miso to 0 within 1 cycle of the synchronized rise.
REQ-027 SHALL NOT pulse frame_done or update last_code when a frame is aborted before B0.
REQ-028 SHALL support sclk half-periods of 3 or more _i_clk cycles; behaviour for shorter half-periods is undefined.
REQ-029 SHALL hold _i_ch0_value and _i_ch1_value as don't-care except in the cycle of the latch.
REQ-030 SHALL hold miso=0 whenever miso_oe=0.

Reset
REQ-031 SHALL, on _i_rst, asynchronously force state IDLE.
REQ-032 SHALL, on _i_rst, clear all outputs to 0.
REQ-033 SHALL, on _i_rst, clear the bit counter and latched code to 0.
REQ-034 SHALL, on _i_rst, preset the cs synchronizer to 1 and the sclk/mosi synchronizers to 0.
REQ-035 SHALL, when _i_rst is asserted mid-frame, abandon the frame with no frame_done.
REQ-036 SHALL, after _i_rst deasserts mid-frame with cs still low, wait in WAIT_START for a new start bit.
REQ-037 SHALL release reset synchronously to _i_clk.

Configuration
REQ-038 SHALL use the macro MCP3002_LSB_TAIL_EN to compile the LSB-first tail in or out.
REQ-039 SHALL, with MCP3002_LSB_TAIL_EN defined and MSBF=0, enter TAIL after B0, drive B1..B9 LSB-first on the next 9 falls, and then enter DONE.
REQ-040 SHALL, with MCP3002_LSB_TAIL_EN undefined, ignore MSBF, go directly from DATA to DONE, and omit the TAIL state logic.

Verification
REQ-041 SHALL cover: ch0=0x2A5; frame start,1,0,1 -> miso per fall 0,1,0,1,0,1,0,0,1,0,1; one frame_done pulse; last_code=0x2A5; last_channel=0.
REQ-042 SHALL cover: ch0=0x100, ch1=0x180; SGL=0, ODD=1 -> code 0x080; same values with ODD=0 -> code 0x000.
REQ-043 SHALL cover: cs raised after 5 sclk cycles -> miso_oe=0 within SYNC_STAGES+2 cycles, no frame_done, last_code unchanged; the next full frame decodes correctly.
REQ-044 SHALL cover: mosi 0,0,0,1,1,1,1 (leading zeros) with ch1=0x3FF -> all ten data bits 1.
REQ-045 SHALL cover: ch1=0x2A5; start,1,1,0; 24 sclk cycles -> with MCP3002_LSB_TAIL_EN the bits after B0 are 0,1,0,0,1,0,1,0,1 then 0s; without it all 0s.
REQ-046 SHALL cover: _i_rst pulsed mid-DATA -> outputs 0 in the same cycle, no frame_done.
